// File: rtl/mips_alu.sv
// EX-stage 32-bit ALU: combinational result/zero/overflow plus a registered copy for EX/MEM.
// Registered outputs capture on every rising clk edge and clear asynchronously on rst_n low.
module mips_alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  alu_control,
   output logic [31:0] result,
   output logic        zero,
   output logic        overflow,
   output logic [31:0] result_q,
   output logic        zero_q,
   output logic        overflow_q
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   logic [31:0] w_result;
   logic        w_overflow;
   logic [4:0]  w_shamt;
   logic [31:0] w_sum;
   logic [31:0] w_diff;

   assign w_shamt = a[4:0];
   assign w_sum   = a + b;
   assign w_diff  = a - b;

   always_comb begin
      w_result   = 32'h0;
      w_overflow = 1'b0;
      case (alu_control)
         OP_AND:  w_result = a & b;
         OP_OR:   w_result = a | b;
         OP_ADD: begin
            w_result   = w_sum;
            w_overflow = (a[31] == b[31]) && (w_sum[31] != a[31]);
         end
         OP_XOR:  w_result = a ^ b;
         OP_SLL:  w_result = b << w_shamt;
         OP_SRL:  w_result = b >> w_shamt;
         OP_SUB: begin
            w_result   = w_diff;
            w_overflow = (a[31] != b[31]) && (w_diff[31] != a[31]);
         end
         // Direct comparisons, so SLT/SLTU stay exact even when a - b would overflow.
         OP_SLT:  w_result = {31'b0, $signed(a) < $signed(b)};
         OP_SRA:  w_result = $signed(b) >>> w_shamt;
         OP_SLTU: w_result = {31'b0, a < b};
         OP_NOR:  w_result = ~(a | b);
         default: w_result = 32'h0;
      endcase
   end

   assign result   = w_result;
   assign zero     = (w_result == 32'h0);
   assign overflow = w_overflow;

   logic [31:0] r_result;
   logic        r_zero;
   logic        r_overflow;

   // zero_q clears with the rest even though result_q is also 0 in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result   <= 32'h0;
         r_zero     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_result   <= w_result;
         r_zero     <= (w_result == 32'h0);
         r_overflow <= w_overflow;
      end
   end

   assign result_q   = r_result;
   assign zero_q     = r_zero;
   assign overflow_q = r_overflow;

endmodule

// File: tb/tb_mips_alu.sv
// Bench for mips_alu: arithmetic reference model with per-cycle compare plus literal test-plan checks.
module tb_mips_alu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] a = 32'h0;
   logic [31:0] b = 32'h0;
   logic [3:0]  alu_control = 4'h0;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic [31:0] result_q;
   logic        zero_q;
   logic        overflow_q;

   int n_cmp = 0;
   int n_bad = 0;

   mips_alu dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a           (a),
      .b           (b),
      .alu_control (alu_control),
      .result      (result),
      .zero        (zero),
      .overflow    (overflow),
      .result_q    (result_q),
      .zero_q      (zero_q),
      .overflow_q  (overflow_q)
   );

   always #5 clk = ~clk;

   localparam longint MAX_S = 64'sd2147483647;
   localparam longint MIN_S = -64'sd2147483648;

   // Reference: signed values widened to 64 bits, overflow = out of 32-bit signed range.
   function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] c,
                                 output logic [31:0] r, output logic ov);
      longint sx;
      longint sy;
      longint s;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = 32'h0;
      ov = 1'b0;
      case (c)
         4'd0:  r = x & y;
         4'd1:  r = x | y;
         4'd2:  begin s = sx + sy; r = s[31:0]; ov = (s > MAX_S) || (s < MIN_S); end
         4'd3:  r = x ^ y;
         4'd4:  r = y << x[4:0];
         4'd5:  r = y >> x[4:0];
         4'd6:  begin s = sx - sy; r = s[31:0]; ov = (s > MAX_S) || (s < MIN_S); end
         4'd7:  r = (sx < sy) ? 32'd1 : 32'd0;
         4'd8:  begin s = sy >>> x[4:0]; r = s[31:0]; end
         4'd9:  r = (x < y) ? 32'd1 : 32'd0;
         4'd12: r = ~(x | y);
         default: r = 32'h0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected registered stage.
   logic [31:0] m_rq = 32'h0;
   logic        m_zq = 1'b0;
   logic        m_oq = 1'b0;
   always @(posedge clk or negedge rst_n) begin
      logic [31:0] r;
      logic        ov;
      if (!rst_n) begin
         m_rq = 32'h0; m_zq = 1'b0; m_oq = 1'b0;
      end else begin
         model(a, b, alu_control, r, ov);
         m_rq = r; m_zq = (r == 32'h0); m_oq = ov;
      end
   end

   // Per-cycle compare on the falling edge.
   always @(negedge clk) begin
      logic [31:0] r;
      logic        ov;
      model(a, b, alu_control, r, ov);
      chk("cyc_result", result, r);
      chk("cyc_zero", {31'b0, zero}, {31'b0, (r == 32'h0)});
      chk("cyc_overflow", {31'b0, overflow}, {31'b0, ov});
      chk("cyc_result_q", result_q, m_rq);
      chk("cyc_zero_q", {31'b0, zero_q}, {31'b0, m_zq});
      chk("cyc_overflow_q", {31'b0, overflow_q}, {31'b0, m_oq});
   end

   task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [3:0] c);
      @(posedge clk);
      #2;
      a = x; b = y; alu_control = c;
      #2;
   endtask

   logic [31:0] pats_a [6];
   logic [31:0] pats_b [6];

   initial begin
      #1;
      chk("rst_result_q", result_q, 32'h0);
      chk("rst_zero_q", {31'b0, zero_q}, 32'h0);
      chk("rst_overflow_q", {31'b0, overflow_q}, 32'h0);
      #10;
      rst_n = 1'b1;

      drive(32'd5, 32'd10, 4'b0010);
      chk("add_result", result, 32'd15);
      chk("add_zero", {31'b0, zero}, 32'd0);
      chk("add_ovf", {31'b0, overflow}, 32'd0);
      @(posedge clk); #1;
      chk("add_result_q", result_q, 32'd15);

      drive(32'd20, 32'd7, 4'b0110);
      chk("sub_result", result, 32'd13);
      chk("sub_zero", {31'b0, zero}, 32'd0);

      drive(32'd8, 32'd8, 4'b0110);
      chk("subz_result", result, 32'd0);
      chk("subz_zero", {31'b0, zero}, 32'd1);
      @(posedge clk); #1;
      chk("subz_zero_q", {31'b0, zero_q}, 32'd1);

      drive(32'h7FFFFFFF, 32'd1, 4'b0010);
      chk("addov_result", result, 32'h80000000);
      chk("addov_ovf", {31'b0, overflow}, 32'd1);
      drive(32'h80000000, 32'd1, 4'b0110);
      chk("subov_result", result, 32'h7FFFFFFF);
      chk("subov_ovf", {31'b0, overflow}, 32'd1);
      drive(32'h80000000, 32'd1, 4'b0000);
      chk("and_ovf", {31'b0, overflow}, 32'd0);
      drive(32'h80000000, 32'd1, 4'b0111);
      chk("slt_min", result, 32'd1);

      drive(32'hFFFFFFFF, 32'd1, 4'b0111);
      chk("slt_result", result, 32'd1);
      drive(32'hFFFFFFFF, 32'd1, 4'b1001);
      chk("sltu_result", result, 32'd0);
      drive(32'd4, 32'h80000000, 4'b1000);
      chk("sra_result", result, 32'hF8000000);
      drive(32'd36, 32'd1, 4'b0100);
      chk("sll_result", result, 32'h10);
      drive(32'd0, 32'd0, 4'b1100);
      chk("nor_result", result, 32'hFFFFFFFF);
      drive(32'h1234, 32'h5678, 4'b1111);
      chk("bad_result", result, 32'd0);
      chk("bad_zero", {31'b0, zero}, 32'd1);

      pats_a = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hDEADBEEF, 32'h0000003F};
      pats_b = '{32'h0, 32'h1, 32'h80000000, 32'hFFFFFFFF, 32'h12345678, 32'hA5A5A5A5};
      for (int p = 0; p < 6; p++) begin
         for (int c = 0; c < 16; c++) begin
            drive(pats_a[p], pats_b[p], c[3:0]);
         end
      end

      drive(32'd5, 32'd10, 4'b0010);
      @(posedge clk); #1;
      chk("pre_rst_result_q", result_q, 32'd15);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_result_q", result_q, 32'd0);
      chk("mid_rst_zero_q", {31'b0, zero_q}, 32'd0);
      chk("mid_rst_overflow_q", {31'b0, overflow_q}, 32'd0);
      chk("mid_rst_result", result, 32'd15);
      @(posedge clk); #1;
      chk("held_rst_result_q", result_q, 32'd0);
      #2;
      rst_n = 1'b1;
      #1;
      chk("rel_rst_result_q", result_q, 32'd0);
      @(posedge clk); #1;
      chk("post_rst_result_q", result_q, 32'd15);
      chk("post_rst_zero_q", {31'b0, zero_q}, 32'd0);

      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
